// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one backend memory port between instruction fetch
// and the load/store unit; one outstanding transaction, completion routed to owner.
module mem_port_arbiter #(
  parameter int INDEX_WIDTH = 64,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pc_index_valid,
  output logic                   pc_index_ready,
  input  logic [INDEX_WIDTH-1:0] pc_index,
  output logic                   pc_operation_done,
  output logic [DATA_WIDTH-1:0]  pc_read_data,
  input  logic                   redirect_flush,
  input  logic                   opload_index_valid,
  output logic                   opload_index_ready,
  input  logic [INDEX_WIDTH-1:0] opload_index,
  output logic                   opload_operation_done,
  output logic [DATA_WIDTH-1:0]  opload_read_data,
  input  logic                   opstore_index_valid,
  output logic                   opstore_index_ready,
  input  logic [INDEX_WIDTH-1:0] opstore_index,
  input  logic [DATA_WIDTH-1:0]  opstore_write_data,
  input  logic [DATA_WIDTH-1:0]  opstore_write_mask,
  output logic                   opstore_operation_done,
  output logic                   ddr_chip_enable,
  input  logic                   ddr_ready,
  output logic [INDEX_WIDTH-1:0] ddr_index,
  output logic                   ddr_write_enable,
  output logic [DATA_WIDTH-1:0]  ddr_write_data,
  output logic [DATA_WIDTH-1:0]  ddr_write_mask,
  input  logic                   ddr_operation_done,
  input  logic [DATA_WIDTH-1:0]  ddr_read_data
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  typedef enum logic [1:0] {OWN_FETCH, OWN_LOAD, OWN_STORE} owner_t;
  typedef enum logic {LG_FETCH, LG_LSU} grant_t;

  state_t                 r_state;
  owner_t                 r_owner;
  grant_t                 r_last_grant;
  logic                   r_squash;
  logic [INDEX_WIDTH-1:0] r_index;
  logic                   r_we;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [DATA_WIDTH-1:0]  r_wmask;

  logic w_lsu_valid, w_fetch_ok, w_grant_lsu, w_grant_fetch;
  logic w_idle, w_wait_done;

  assign w_lsu_valid   = opload_index_valid | opstore_index_valid;
  assign w_fetch_ok    = pc_index_valid & ~redirect_flush;
  // On a tie the requester not granted last time wins.
  assign w_grant_lsu   = w_lsu_valid & (~w_fetch_ok | (r_last_grant == LG_FETCH));
  assign w_grant_fetch = w_fetch_ok & (~w_lsu_valid | (r_last_grant == LG_LSU));
  assign w_idle        = (r_state == S_IDLE);
  assign w_wait_done   = (r_state == S_WAIT) & ddr_operation_done;

  // Readies are gated by reset so nothing fires while reset is held.
  assign pc_index_ready      = ~reset & w_idle & w_grant_fetch;
  assign opstore_index_ready = ~reset & w_idle & w_grant_lsu & opstore_index_valid;
  assign opload_index_ready  = ~reset & w_idle & w_grant_lsu & ~opstore_index_valid;

  assign pc_operation_done      = w_wait_done & (r_owner == OWN_FETCH) & ~r_squash & ~redirect_flush;
  assign opload_operation_done  = w_wait_done & (r_owner == OWN_LOAD);
  assign opstore_operation_done = w_wait_done & (r_owner == OWN_STORE);
  assign pc_read_data     = (w_wait_done & (r_owner == OWN_FETCH)) ? ddr_read_data : '0;
  assign opload_read_data = (w_wait_done & (r_owner == OWN_LOAD))  ? ddr_read_data : '0;

  assign ddr_chip_enable  = (r_state == S_REQ);
  assign ddr_index        = r_index;
  assign ddr_write_enable = r_we;
  assign ddr_write_data   = r_wdata;
  assign ddr_write_mask   = r_wmask;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_FETCH;
      r_last_grant <= LG_FETCH;
      r_squash     <= 1'b0;
      r_index      <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_lsu) begin
            r_owner      <= opstore_index_valid ? OWN_STORE : OWN_LOAD;
            r_index      <= opstore_index_valid ? opstore_index : opload_index;
            r_we         <= opstore_index_valid;
            r_wdata      <= opstore_index_valid ? opstore_write_data : '0;
            r_wmask      <= opstore_index_valid ? opstore_write_mask : '0;
            r_last_grant <= LG_LSU;
            r_state      <= S_REQ;
          end else if (w_grant_fetch) begin
            r_owner      <= OWN_FETCH;
            r_index      <= pc_index;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_last_grant <= LG_FETCH;
            r_state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (redirect_flush && (r_owner == OWN_FETCH)) r_squash <= 1'b1;
          if (ddr_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (ddr_operation_done) begin
            r_squash <= 1'b0;
            r_state  <= S_IDLE;
          end else if (redirect_flush && (r_owner == OWN_FETCH)) begin
            r_squash <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: table of transactions plus hand-written arbitration,
// squash and reset sequences; expected commands are queued at grant time.
module tb_mem_port_arbiter;

  typedef enum int {O_FETCH, O_LOAD, O_STORE} own_e;
  typedef struct {
    own_e        own;
    logic [63:0] idx;
    logic [63:0] wd;
    logic [63:0] mk;
    logic [63:0] rd;
    int          rdly;
    int          ddly;
  } vec_t;
  typedef struct {
    own_e        own;
    logic [63:0] idx;
    logic        we;
    logic [63:0] wd;
    logic [63:0] mk;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pc_index_valid = 1'b0, pc_index_ready;
  logic [63:0] pc_index = '0;
  logic        pc_operation_done;
  logic [63:0] pc_read_data;
  logic        redirect_flush = 1'b0;
  logic        opload_index_valid = 1'b0, opload_index_ready;
  logic [63:0] opload_index = '0;
  logic        opload_operation_done;
  logic [63:0] opload_read_data;
  logic        opstore_index_valid = 1'b0, opstore_index_ready;
  logic [63:0] opstore_index = '0, opstore_write_data = '0, opstore_write_mask = '0;
  logic        opstore_operation_done;
  logic        ddr_chip_enable, ddr_ready = 1'b0, ddr_write_enable;
  logic [63:0] ddr_index, ddr_write_data, ddr_write_mask;
  logic        ddr_operation_done = 1'b0;
  logic [63:0] ddr_read_data = '0;

  int passed = 0;
  int total  = 0;
  exp_t q[$];
  vec_t vecs[5];

  mem_port_arbiter #(.INDEX_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clock(clock), .reset(reset),
    .pc_index_valid(pc_index_valid), .pc_index_ready(pc_index_ready), .pc_index(pc_index),
    .pc_operation_done(pc_operation_done), .pc_read_data(pc_read_data),
    .redirect_flush(redirect_flush),
    .opload_index_valid(opload_index_valid), .opload_index_ready(opload_index_ready),
    .opload_index(opload_index), .opload_operation_done(opload_operation_done),
    .opload_read_data(opload_read_data),
    .opstore_index_valid(opstore_index_valid), .opstore_index_ready(opstore_index_ready),
    .opstore_index(opstore_index), .opstore_write_data(opstore_write_data),
    .opstore_write_mask(opstore_write_mask), .opstore_operation_done(opstore_operation_done),
    .ddr_chip_enable(ddr_chip_enable), .ddr_ready(ddr_ready), .ddr_index(ddr_index),
    .ddr_write_enable(ddr_write_enable), .ddr_write_data(ddr_write_data),
    .ddr_write_mask(ddr_write_mask), .ddr_operation_done(ddr_operation_done),
    .ddr_read_data(ddr_read_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    else passed++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_cmd(input string nm);
    chk({nm, "_en"},   ddr_chip_enable, 1'b1);
    chk({nm, "_idx"},  ddr_index, q[0].idx);
    chk({nm, "_we"},   ddr_write_enable, q[0].we);
    chk({nm, "_wd"},   ddr_write_data, q[0].wd);
    chk({nm, "_mask"}, ddr_write_mask, q[0].mk);
  endtask

  // Waits for a grant, checks the winner, then plays the memory side.
  task automatic serve(input own_e own, input logic [63:0] rd, input int rdly, input int ddly,
                       input bit drop, input bit sq);
    exp_t e;
    int   n;
    n = 0;
    #1;
    while (!(pc_index_ready | opload_index_ready | opstore_index_ready) && n < 20) begin
      step(); #1; n++;
    end
    if (n >= 20) begin
      chk("grant_timeout", 1'b0, 1'b1);
      return;
    end
    chk("pc_ready",    pc_index_ready,      own == O_FETCH);
    chk("load_ready",  opload_index_ready,  own == O_LOAD);
    chk("store_ready", opstore_index_ready, own == O_STORE);
    e.own = own;
    e.idx = (own == O_FETCH) ? pc_index : (own == O_LOAD) ? opload_index : opstore_index;
    e.we  = (own == O_STORE);
    e.wd  = (own == O_STORE) ? opstore_write_data : 64'h0;
    e.mk  = (own == O_STORE) ? opstore_write_mask : 64'h0;
    q.push_back(e);
    step();
    if (drop) begin
      case (own)
        O_FETCH: pc_index_valid = 1'b0;
        O_LOAD:  opload_index_valid = 1'b0;
        default: begin opstore_index_valid = 1'b0; opload_index_valid = 1'b0; end
      endcase
    end
    #1;
    chk_cmd("req");
    for (int i = 0; i < rdly; i++) begin
      opstore_write_data = $urandom;
      opstore_index      = opstore_index ^ 64'h5;
      step(); #1;
      chk_cmd("stall");
    end
    ddr_ready = 1'b1;
    #1;
    chk("en_at_ready", ddr_chip_enable, 1'b1);
    step();
    ddr_ready = 1'b0;
    #1;
    chk("en_after_ready", ddr_chip_enable, 1'b0);
    if (sq) begin
      redirect_flush = 1'b1;
      #1;
      step();
      redirect_flush = 1'b0;
      #1;
    end
    for (int i = 0; i < ddly; i++) step();
    ddr_operation_done = 1'b1;
    ddr_read_data      = rd;
    #1;
    e = q.pop_front();
    chk("load_done",  opload_operation_done,  e.own == O_LOAD);
    chk("store_done", opstore_operation_done, e.own == O_STORE);
    chk("pc_done",    pc_operation_done,      (e.own == O_FETCH) && !sq);
    chk("load_rdata", opload_read_data, (e.own == O_LOAD) ? rd : 64'h0);
    if (!sq) chk("pc_rdata", pc_read_data, (e.own == O_FETCH) ? rd : 64'h0);
    step();
    ddr_operation_done = 1'b0;
    ddr_read_data      = '0;
    #1;
    chk("done_once", {61'h0, pc_operation_done, opload_operation_done, opstore_operation_done}, 64'h0);
  endtask

  task automatic drive(input vec_t v);
    case (v.own)
      O_FETCH: begin pc_index = v.idx; pc_index_valid = 1'b1; end
      O_LOAD:  begin opload_index = v.idx; opload_index_valid = 1'b1; end
      default: begin
        opstore_index = v.idx; opstore_write_data = v.wd;
        opstore_write_mask = v.mk; opstore_index_valid = 1'b1;
      end
    endcase
  endtask

  initial begin
    vecs[0] = '{O_LOAD,  64'h10,  64'h0,  64'h0,  64'hDEAD, 2, 1};
    vecs[1] = '{O_STORE, 64'h4,   64'hAB, 64'hFF, 64'h0,    4, 1};
    vecs[2] = '{O_FETCH, 64'h100, 64'h0,  64'h0,  64'h1234, 1, 2};
    vecs[3] = '{O_LOAD,  '1,      64'h0,  64'h0,  '1,       0, 0};
    vecs[4] = '{O_STORE, '1,      '1,     '1,     64'h0,    0, 0};

    pc_index_valid = 1'b1;
    opload_index_valid = 1'b1;
    #2;
    chk("rst_en",       ddr_chip_enable, 1'b0);
    chk("rst_pc_ready", pc_index_ready, 1'b0);
    chk("rst_ld_ready", opload_index_ready, 1'b0);
    chk("rst_idx",      ddr_index, 64'h0);
    chk("rst_we",       ddr_write_enable, 1'b0);
    pc_index_valid = 1'b0;
    opload_index_valid = 1'b0;
    step(); step();
    reset = 1'b0;

    foreach (vecs[i]) begin
      step();
      drive(vecs[i]);
      serve(vecs[i].own, vecs[i].rd, vecs[i].rdly, vecs[i].ddly, 1'b1, 1'b0);
    end

    // Load and store together: store wins, load is not readied.
    opload_index = 64'h21; opload_index_valid = 1'b1;
    opstore_index = 64'h22; opstore_write_data = 64'h77; opstore_write_mask = 64'hF0;
    opstore_index_valid = 1'b1;
    serve(O_STORE, 64'h0, 1, 0, 1'b1, 1'b0);

    // Continuous fetch + load from reset: strict alternation starting with LSU.
    reset = 1'b1; #1; reset = 1'b0;
    pc_index = 64'h40; opload_index = 64'h80;
    pc_index_valid = 1'b1; opload_index_valid = 1'b1;
    serve(O_LOAD,  64'h1, 0, 0, 1'b0, 1'b0);
    serve(O_FETCH, 64'h2, 1, 0, 1'b0, 1'b0);
    serve(O_LOAD,  64'h3, 0, 1, 1'b0, 1'b0);
    serve(O_FETCH, 64'h4, 0, 0, 1'b0, 1'b0);
    pc_index_valid = 1'b0; opload_index_valid = 1'b0;

    // Squashed fetch, then a normal fetch.
    step();
    pc_index = 64'h200; pc_index_valid = 1'b1;
    serve(O_FETCH, 64'hBAD, 1, 1, 1'b1, 1'b1);
    pc_index = 64'h204; pc_index_valid = 1'b1;
    serve(O_FETCH, 64'h600D, 0, 1, 1'b1, 1'b0);

    // Redirect in IDLE blocks the fetch grant but not the LSU.
    pc_index_valid = 1'b1; opload_index_valid = 1'b1; redirect_flush = 1'b1;
    #1;
    chk("flush_pc_ready", pc_index_ready, 1'b0);
    chk("flush_ld_ready", opload_index_ready, 1'b1);
    pc_index_valid = 1'b0; opload_index_valid = 1'b0; redirect_flush = 1'b0;

    // Reset during REQ abandons the transaction.
    step();
    opload_index = 64'h55; opload_index_valid = 1'b1;
    step();
    opload_index_valid = 1'b0;
    #1;
    chk("pre_rst_en", ddr_chip_enable, 1'b1);
    reset = 1'b1; pc_index_valid = 1'b1;
    #1;
    chk("mid_rst_en",       ddr_chip_enable, 1'b0);
    chk("mid_rst_pc_ready", pc_index_ready, 1'b0);
    chk("mid_rst_idx",      ddr_index, 64'h0);
    step();
    reset = 1'b0;
    ddr_operation_done = 1'b1; ddr_read_data = 64'h99;
    #1;
    chk("stray_done", {61'h0, pc_operation_done, opload_operation_done, opstore_operation_done}, 64'h0);
    ddr_operation_done = 1'b0; ddr_read_data = '0;
    opload_index = 64'h66; opload_index_valid = 1'b1;
    serve(O_LOAD,  64'h11, 0, 0, 1'b1, 1'b0);
    serve(O_FETCH, 64'h22, 0, 0, 1'b1, 1'b0);

    chk("queue_empty", q.size(), 64'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single backend memory (DDR/SRAM) port between the instruction-fetch requester (`pc_*`) and the load/store stage (`opload_*` / `opstore_*`). It runs one transaction at a time, granting fetch and load/store round-robin. It latches the granted command, drives it downstream until accepted, and routes the completion and read data back to the owner. A frontend redirect squashes the completion of an in-flight fetch.

## Interface
- `INDEX_WIDTH`, 64, width of the 64-bit-word index on every port.
- `DATA_WIDTH`, 64, width of read/write data; write mask is one bit per data bit.

Ports (one clock; reset is asynchronous and active-high):
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc_index_valid`  in  1  fetch read request.
- `pc_index_ready`  out  1  fetch request accepted this cycle.
- `pc_index`  in  INDEX_WIDTH  fetch word index.
- `pc_operation_done`  out  1  fetch completion pulse.
- `pc_read_data`  out  DATA_WIDTH  fetch read data, valid with done.
- `redirect_flush`  in  1  frontend redirect; squashes the fetch.
- `opload_index_valid` / `opload_index_ready`  in/out  1  load request handshake.
- `opload_index`  in  INDEX_WIDTH  load word index.
- `opload_operation_done`  out  1  load completion pulse.
- `opload_read_data`  out  DATA_WIDTH  load read data.
- `opstore_index_valid` / `opstore_index_ready`  in/out  1  store request handshake.
- `opstore_index`  in  INDEX_WIDTH  store word index.
- `opstore_write_data`  in  DATA_WIDTH  store data.
- `opstore_write_mask`  in  DATA_WIDTH  per-bit write enable.
- `opstore_operation_done`  out  1  store completion pulse.
- `ddr_chip_enable`  out  1  downstream request valid.
- `ddr_ready`  in  1  downstream accepts the request.
- `ddr_index`  out  INDEX_WIDTH  latched index.
- `ddr_write_enable`  out  1  1 for store, 0 for read.
- `ddr_write_data` / `ddr_write_mask`  out  DATA_WIDTH  latched store data and mask; 0 for reads.
- `ddr_operation_done`  in  1  downstream completion pulse.
- `ddr_read_data`  in  DATA_WIDTH  downstream read data, valid with done.

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE: choose a winner among requesters.
  - LSU is valid when `opload_index_valid | opstore_index_valid`. If both are set, the store wins and the load is not readied.
  - Fetch is eligible only when `pc_index_valid & ~redirect_flush`.
  - When LSU and fetch both request, the one not granted last wins. The `last_grant` register resets to "fetch", so LSU wins the first tie.
  - The winner's `*_ready` is driven high combinationally. On that fire, latch owner (FETCH/LOAD/STORE), index, write_enable, data and mask. Update `last_grant`. Go to REQ.
- REQ: `ddr_chip_enable`=1 with the latched command. All `*_ready` are 0. On `ddr_ready`, go to WAIT.
- WAIT: `ddr_chip_enable`=0. On `ddr_operation_done`:
  - Pulse the owner's `*_operation_done` combinationally in the same cycle.
  - Pass `ddr_read_data` to the owner's read data, which is 0 for other owners.
  - Go to IDLE.
- Squash:
  - `redirect_flush` while the owner is FETCH in REQ or WAIT sets `squash`.
  - A squashed fetch still runs to completion downstream, but `pc_operation_done` is suppressed.
  - `squash` clears on the return to IDLE.
  - `redirect_flush` in IDLE blocks a fetch grant; the LSU may still be granted that cycle.
- A `ddr_operation_done` seen in IDLE or REQ is ignored; it is a protocol error and may be asserted on in the bench.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, latched regs=0, `squash`=0, `last_grant`=fetch.
  - All `*_ready` and `*_operation_done` outputs, `ddr_chip_enable`, `ddr_write_enable` and `ddr_index`/data/mask are 0 while `reset` is high.
- Reset mid-transaction abandons the transaction; no done pulse is emitted.
- Request fire in cycle N → `ddr_chip_enable` high from N+1.
- `ddr_ready` in cycle M → `ddr_chip_enable` low in M+1.
- `ddr_operation_done` in cycle K → owner done in K (zero latency). A new grant is possible from K+1.
- Minimum occupancy is 3 cycles per transaction (fire, REQ with ready, WAIT with done).
- `ddr_*` command outputs hold stable throughout REQ regardless of requester inputs.

## Test plan
- Single load, index 0x10: fire in cycle 0. `ddr_chip_enable`=1 in cycle 1 with `ddr_index`=0x10 and `ddr_write_enable`=0. `ddr_ready` in cycle 3, done in cycle 5 with data 0xDEAD → `opload_operation_done`=1 and `opload_read_data`=0xDEAD in cycle 5.
- Store, mask 0xFF, data 0xAB, index 4 → `ddr_write_enable`=1, mask 0xFF and data 0xAB held through a 4-cycle `ddr_ready` stall. `opstore_operation_done` pulses once; `pc_operation_done` stays 0.
- Fetch and load requested continuously after reset → grant order is load, fetch, load, fetch. No requester waits more than one transaction.
- Fetch granted, then `redirect_flush` pulsed in WAIT → the downstream done completes the transaction, `pc_operation_done` stays 0, and the next fetch completes normally.
- `opload_index_valid` and `opstore_index_valid` both 1 → only `opstore_index_ready` asserts; `ddr_write_enable`=1.
- `reset` asserted during REQ → `ddr_chip_enable` drops immediately. After release, state is IDLE and the first tie goes to LSU.
